// File: rtl/mdu_hilo.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO; result 34 cycles after start (WIDTH+2).
// start is ignored while busy (no queueing); MDU_DIVZERO_FAST_EN finishes divide-by-zero in 2 cycles.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             op_q;
  logic [WIDTH-1:0]       a_q, b_q, mb;
  logic [2*WIDTH-1:0]     acc;
  logic                   neg_res, neg_rem;
  logic [CW-1:0]          cnt;

  logic                   is_div, is_signed, b_zero;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH:0]         mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       quo, rem;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign b_zero    = (b_q == '0);
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mb : {WIDTH{1'b0}})};
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, mb};
  assign prod      = neg_res ? -acc : acc;
  assign quo       = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem       = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == FIX);
    case (state)
      IDLE: if (start) state_nxt = PREP;
      PREP: begin
`ifdef MDU_DIVZERO_FAST_EN
        if (is_div && b_zero) state_nxt = FIX;
        else                  state_nxt = RUN;
`else
        state_nxt = RUN;
`endif
      end
      RUN:  if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc     <= '0;
      mb      <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= A;
            b_q  <= B;
          end
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
        PREP: begin
          neg_res <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem <= is_signed & a_q[WIDTH-1];
          cnt     <= CW'(WIDTH);
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, mag_a};
            mb  <= mag_b;
          end else begin
            acc <= {{WIDTH{1'b0}}, mag_b};
            mb  <= mag_a;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (!is_div)
            acc <= {mul_sum, acc[WIDTH-1:1]};
          else if (!div_diff[WIDTH])
            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (b_zero) begin
            // dividend goes to HI raw (not its magnitude) so DIV by zero matches DIVU
            hi <= a_q;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
